// File: rtl/core_pkg.sv
// Shared front-end types: PC generator states, redirect-source encoding and
// default widths, plus the instruction-alignment test used on redirect targets.
package core_pkg;
    localparam int DEF_XLEN   = 32;
    localparam int DEF_IALIGN = 32;

    typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
    typedef enum logic [2:0] {NONE, TRAP, MRET, EX, ID, SEQ} redir_src_e;

    function automatic logic is_misaligned(input logic [1:0] lo, input int ialign);
        return (ialign == 16) ? lo[0] : (lo != 2'b00);
    endfunction
endpackage

// File: rtl/pc_redir_arb.sv
// Combinational next-PC priority selector: picks the winning source, its target
// and whether that target violates instruction alignment.
module pc_redir_arb
    import core_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int IALIGN = DEF_IALIGN
) (
    input  pc_state_e        i_state,
    input  logic             i_fetch_fire,
    input  logic [XLEN-1:0]  i_fetch_pc,
    input  logic             i_trap_take,
    input  logic [XLEN-1:0]  i_trap_addr,
    input  logic             i_mret_take,
    input  logic [XLEN-1:0]  i_mepc,
    input  logic             i_ex_redir,
    input  logic             i_ex_is_jalr,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_id_jal,
    input  logic [XLEN-1:0]  i_id_pc,
    input  logic [20:0]      i_id_jal_imm,
    output redir_src_e       o_src,
    output logic [XLEN-1:0]  o_target,
    output logic             o_misaligned
);
    logic [XLEN-1:0] w_ex_tgt;
    logic [XLEN-1:0] w_jal_tgt;
    logic [XLEN-1:0] w_seq_tgt;

    assign w_ex_tgt  = {i_ex_target[XLEN-1:1], i_ex_target[0] & ~i_ex_is_jalr};
    assign w_jal_tgt = i_id_pc + {{(XLEN-21){i_id_jal_imm[20]}}, i_id_jal_imm};
    assign w_seq_tgt = (i_fetch_pc & ~XLEN'(3)) + XLEN'(4);

    // Only EX and ID targets are alignment-checked; trap/mret go through as-is.
    always_comb begin
        o_src        = NONE;
        o_target     = i_fetch_pc;
        o_misaligned = 1'b0;
        case (i_state)
            RUN: begin
                if (i_trap_take) begin
                    o_src    = TRAP;
                    o_target = i_trap_addr;
                end else if (i_mret_take) begin
                    o_src    = MRET;
                    o_target = i_mepc;
                end else if (i_ex_redir) begin
                    o_src        = EX;
                    o_target     = w_ex_tgt;
                    o_misaligned = is_misaligned(w_ex_tgt[1:0], IALIGN);
                end else if (i_id_jal) begin
                    o_src        = ID;
                    o_target     = w_jal_tgt;
                    o_misaligned = is_misaligned(w_jal_tgt[1:0], IALIGN);
                end else if (i_fetch_fire) begin
                    o_src    = SEQ;
                    o_target = w_seq_tgt;
                end
            end
            HALT: begin
                if (i_trap_take) begin
                    o_src    = TRAP;
                    o_target = i_trap_addr;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: holds the architectural fetch PC, applies arbitrated
// redirects, tags fetches with an epoch and handles debug/WFI halt.
module pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = DEF_IALIGN,
    parameter int              EPOCH_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    fetch_pc,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [EPOCH_W-1:0] fetch_epoch,
    input  logic               trap_take,
    input  logic [XLEN-1:0]    trap_addr,
    input  logic               mret_take,
    input  logic [XLEN-1:0]    mepc,
    input  logic               ex_redir,
    input  logic               ex_is_jalr,
    input  logic [XLEN-1:0]    ex_target,
    input  logic               id_jal,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [20:0]        id_jal_imm,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic               misalign_exc,
    output logic [XLEN-1:0]    misalign_addr
);
    pc_state_e          r_state;
    logic [XLEN-1:0]    r_pc;
    logic               r_valid;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_halted;
    logic               r_exc;
    logic [XLEN-1:0]    r_exc_addr;

    redir_src_e         w_src;
    logic [XLEN-1:0]    w_target;
    logic               w_misaligned;
    pc_state_e          w_next_state;

    pc_redir_arb #(.XLEN(XLEN), .IALIGN(IALIGN)) u_arb (
        .i_state      (r_state),
        .i_fetch_fire (r_valid & fetch_ready),
        .i_fetch_pc   (r_pc),
        .i_trap_take  (trap_take),
        .i_trap_addr  (trap_addr),
        .i_mret_take  (mret_take),
        .i_mepc       (mepc),
        .i_ex_redir   (ex_redir),
        .i_ex_is_jalr (ex_is_jalr),
        .i_ex_target  (ex_target),
        .i_id_jal     (id_jal),
        .i_id_pc      (id_pc),
        .i_id_jal_imm (id_jal_imm),
        .o_src        (w_src),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     if (halt_req) w_next_state = HALT;
            HALT:    if (resume || trap_take) w_next_state = RUN;
            default: w_next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_valid    <= 1'b0;
            r_epoch    <= '0;
            r_halted   <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_state  <= w_next_state;
            r_valid  <= (w_next_state == RUN);
            r_halted <= (w_next_state == HALT);
            r_exc    <= 1'b0;
            case (w_src)
                TRAP, MRET, EX, ID: begin
                    // A misaligned target is reported instead of applied.
                    if (w_misaligned) begin
                        r_exc      <= 1'b1;
                        r_exc_addr <= w_target;
                    end else begin
                        r_pc    <= w_target;
                        r_epoch <= r_epoch + EPOCH_W'(1);
                    end
                end
                SEQ:     r_pc <= w_target;
                default: ;
            endcase
        end
    end

    assign fetch_pc      = r_pc;
    assign fetch_valid   = r_valid;
    assign fetch_epoch   = r_epoch;
    assign halted        = r_halted;
    assign misalign_exc  = r_exc;
    assign misalign_addr = r_exc_addr;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-PC generator for the core front end. It holds the architectural fetch PC and arbitrates redirect sources (trap, mret, execute-stage branch/jalr, decode-stage jal). It checks redirect targets for instruction-address misalignment, supports debug/WFI halt, and tags every fetch with an epoch so downstream stages can drop wrong-path instructions.

## Interface
- `XLEN`, 32, address width.
- `RESET_VEC`, 0, PC value after reset.
- `IALIGN`, 32, instruction alignment in bits; 32 or 16 (C extension).
- `EPOCH_W`, 2, epoch counter width.
- `clk` in 1 — core clock.
- `rst` in 1 — synchronous, active-high reset.
- `fetch_pc` out XLEN — current fetch address.
- `fetch_valid` out 1 — `fetch_pc` is valid.
- `fetch_ready` in 1 — fetch accepts `fetch_pc` this cycle.
- `fetch_epoch` out EPOCH_W — epoch tag of `fetch_pc`.
- `trap_take` in 1, `trap_addr` in XLEN — trap entry.
- `mret_take` in 1, `mepc` in XLEN — return from trap.
- `ex_redir` in 1, `ex_is_jalr` in 1, `ex_target` in XLEN — taken branch or jalr from EX.
- `id_jal` in 1, `id_pc` in XLEN, `id_jal_imm` in 21 — jal detected in ID.
- `halt_req` in 1, `resume` in 1 — enter/leave halt.
- `halted` out 1 — in HALT state.
- `misalign_exc` out 1, `misalign_addr` out XLEN — misaligned-target exception pulse and the offending address.

## Operation
- States: `BOOT`, `RUN`, `HALT`.
  - Reset sets `BOOT`, `fetch_pc`=`RESET_VEC`, `fetch_valid`=0, `fetch_epoch`=0, `halted`=0, `misalign_exc`=0, `misalign_addr`=0.
  - `BOOT`→`RUN` unconditionally after one cycle.
  - `RUN`→`HALT` on `halt_req`.
  - `HALT`→`RUN` on `resume` or `trap_take`.
- `fetch_valid`=1 only in `RUN`.
- Next-PC priority, highest first:
  1. `trap_take` → `trap_addr`.
  2. `mret_take` → `mepc`.
  3. `ex_redir` → `ex_target`; bit 0 is cleared when `ex_is_jalr`.
  4. `id_jal` → `id_pc` + sign-extended `id_jal_imm`, computed modulo 2^XLEN.
  5. Fetch fire (`fetch_valid` & `fetch_ready`) → (`fetch_pc` with the low 2 bits cleared) + 4.
  6. Otherwise hold.
- Misalignment check applies to sources 3 and 4 only.
  - The selected target is misaligned if bits [1:0]≠0 when IALIGN=32, or bit 0≠0 when IALIGN=16.
  - A misaligned target is not applied: PC holds, the epoch does not change, and `misalign_exc` pulses for one cycle with `misalign_addr` = target.
  - Recovery happens through the trap unit's later `trap_take`.
- Trap and mret targets are applied unchecked.
- Every applied redirect (sources 1–4) increments `fetch_epoch`, wrapping modulo 2^EPOCH_W.
- A lower-priority source present in the same cycle is discarded, not queued.
- Redirects are applied even when `fetch_ready`=0.
- In `HALT`, only `trap_take` is applied; all other sources are ignored.
- In `BOOT`, all redirect inputs are ignored.
- `halt_req` and a redirect in the same `RUN` cycle: the redirect is applied, then the block enters `HALT`.

## Timing
- All outputs are registered.
- Redirect asserted in cycle N: `fetch_pc`, `fetch_epoch` and `misalign_exc` are updated at N+1.
- A fetch fire in cycle N advances `fetch_pc` at N+1; the next-PC path has zero bubbles.
- A fetch stall holds `fetch_pc` and `fetch_epoch` stable while `fetch_valid`=1.
- Reset asserted mid-operation overrides everything in the same edge and returns to the reset values above.
- `halted` rises the cycle after `halt_req` is accepted and falls the cycle after exit.

## Structure
- Shared package `core_pkg` holds:
  - the state enum `pc_state_e` (`BOOT`/`RUN`/`HALT`);
  - the redirect-source encoding `redir_src_e` (`NONE`/`TRAP`/`MRET`/`EX`/`ID`/`SEQ`);
  - `XLEN` and `IALIGN` defaults.
- One sub-module, `pc_redir_arb`: a combinational priority selector producing the source, target and misaligned flag. The state, PC and epoch registers stay in `pc_gen`.

## Test plan
- Reset with `RESET_VEC`=0x8000_0000, then hold `fetch_ready`=1 → `fetch_valid` rises on cycle 2; `fetch_pc` steps 0x8000_0000, …04, …08; epoch stays 0.
- Same cycle `trap_take` (`trap_addr`=0x100) + `ex_redir` (`ex_target`=0x200) + `id_jal` → next PC 0x100, epoch +1; the 0x200 target is never seen.
- `ex_redir`, `ex_is_jalr`=1, `ex_target`=0x1003, IALIGN=32 → bit 0 cleared to 0x1002, which is misaligned; `misalign_exc`=1 for one cycle, `misalign_addr`=0x1002, PC and epoch unchanged. With IALIGN=16, PC=0x1002 and epoch +1.
- `id_jal`, `id_pc`=0x10, `id_jal_imm`=0x1FFFF0 (−16) → PC 0x0; then four more redirects with EPOCH_W=2 → epoch wraps 3→0.
- `fetch_ready`=0 for 3 cycles → PC held; `ex_redir` mid-stall to 0x40 → PC 0x40 the next cycle despite the stall.
- `halt_req` → `halted`=1, `fetch_valid`=0, `ex_redir` ignored; `trap_take` to 0x300 → exit to `RUN`, PC 0x300; `rst` mid-`HALT` → `BOOT`, PC=`RESET_VEC`.
